// File: rtl/spi_pkg.sv
// spi_pkg: shared states and W5500 control-byte field layout for the SPI responder.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, SKIP} spi_slv_state_t;

    localparam logic       RWB_WRITE = 1'b1;
    localparam logic [1:0] OM_VDM    = 2'b00;

    localparam int BSB_MSB = 7;
    localparam int BSB_LSB = 3;
    localparam int RWB_BIT = 2;
    localparam int OM_MSB  = 1;
    localparam int OM_LSB  = 0;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            prev <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave decoding a W5500-style 24-bit header and
// streaming data bytes to/from a byte-wide register port; sclk is only ever sampled.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int CLK_PER_SCLK = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        scsn,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [15:0] reg_addr,
    output logic [4:0]  reg_bsb,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    if (CLK_PER_SCLK < 2 * SYNC_STAGES + 4) begin : g_rate_check
        $error("spi_slave_responder: CLK_PER_SCLK too small for SYNC_STAGES");
    end

    spi_slv_state_t state, state_nxt;

    logic        sclk_q, sclk_rise, sclk_fall;
    logic        scsn_q, scsn_rise, scsn_fall;
    logic        mosi_q, mosi_rise, mosi_fall;
    logic        unused_sync;
    logic [2:0]  bitcnt;
    logic [1:0]  hdrcnt;
    logic [6:0]  rxsr;
    logic [7:0]  txsr;
    logic [15:0] addr;
    logic        rd_pend;
    logic        wr_go, rd_go, done_go, err_go;
    logic        active, rise_a, fall_a, byte_done, hdr_last;
    logic [7:0]  byte_val;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scsn (
        .clk(clk), .rst(rst), .din(scsn), .q(scsn_q), .rise(scsn_rise), .fall(scsn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_q, mosi_rise, mosi_fall};

    assign active    = state inside {HDR, WDATA, RDATA};
    assign rise_a    = sclk_rise & ~scsn_q & active;
    assign fall_a    = sclk_fall & ~scsn_q & (state == RDATA);
    assign byte_val  = {rxsr, mosi_q};
    assign byte_done = rise_a & (bitcnt == 3'd7);
    assign hdr_last  = byte_done & (state == HDR) & (hdrcnt == 2'd2);
    assign busy      = ~scsn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        done_go   = 1'b0;
        err_go    = 1'b0;
        case (state)
            IDLE: state_nxt = scsn_fall ? HDR : IDLE;
            HDR: begin
                if (scsn_rise) begin
                    state_nxt = IDLE;
                    // a select glitch with no sclk activity is not reported
                    err_go    = (hdrcnt != 2'd0) || (bitcnt != 3'd0);
                end else if (hdr_last) begin
                    state_nxt = (byte_val[OM_MSB:OM_LSB] != OM_VDM) ? SKIP :
                                (byte_val[RWB_BIT] == RWB_WRITE)   ? WDATA : RDATA;
                    err_go    = byte_val[OM_MSB:OM_LSB] != OM_VDM;
                    rd_go     = state_nxt == RDATA;
                end
            end
            WDATA, RDATA: begin
                if (scsn_rise) begin
                    state_nxt = IDLE;
                    err_go    = bitcnt != 3'd0;
                    done_go   = bitcnt == 3'd0;
                end else begin
                    wr_go = byte_done & (state == WDATA);
                    rd_go = byte_done & (state == RDATA);
                end
            end
            SKIP:    state_nxt = scsn_rise ? IDLE : SKIP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt     <= '0;
            hdrcnt     <= '0;
            rxsr       <= '0;
            txsr       <= '0;
            addr       <= '0;
            rd_pend    <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            reg_addr   <= '0;
            reg_bsb    <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            reg_wr     <= wr_go;
            reg_rd     <= rd_go;
            rd_pend    <= reg_rd;
            frame_done <= done_go;
            frame_err  <= err_go;
            if (scsn_fall) begin
                bitcnt <= '0;
                hdrcnt <= '0;
            end
            if (rise_a) begin
                rxsr   <= byte_val[6:0];
                bitcnt <= bitcnt + 3'd1;
            end
            if (byte_done && state == HDR) begin
                hdrcnt <= hdrcnt + 2'd1;
                if (hdrcnt == 2'd0) addr[15:8] <= byte_val;
                if (hdrcnt == 2'd1) addr[7:0]  <= byte_val;
                if (hdrcnt == 2'd2) reg_bsb    <= byte_val[BSB_MSB:BSB_LSB];
            end
            if (wr_go) begin
                reg_wdata <= byte_val;
                reg_addr  <= addr;
            end
            // the header read fetches addr itself; later reads prefetch the next byte
            if (rd_go) reg_addr <= (state == RDATA) ? addr + 16'd1 : addr;
            if (wr_go || (rd_go && state == RDATA)) addr <= addr + 16'd1;
            if (rd_pend && state == RDATA) begin
                txsr    <= reg_rdata;
                miso_oe <= 1'b1;
            end else if (fall_a) begin
                miso <= (bitcnt == 3'd0) ? txsr[7] : txsr[6];
                if (bitcnt != 3'd0) txsr <= {txsr[6:0], 1'b0};
            end
            if (scsn_rise) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed SPI frames with a queue scoreboard checked by a register-port monitor.
module tb_spi_slave_responder;

    localparam int CLK_PER_SCLK = 16;
    localparam int HALF         = CLK_PER_SCLK / 2;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [4:0]  bsb;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, scsn, mosi;
    logic        miso, miso_oe;
    logic [15:0] reg_addr;
    logic [4:0]  reg_bsb;
    logic [7:0]  reg_wdata;
    logic        reg_wr, reg_rd;
    logic [7:0]  reg_rdata;
    logic        frame_done, frame_err, busy;
    logic [35:0] outs;

    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    spi_slave_responder #(.CLK_PER_SCLK(CLK_PER_SCLK), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .scsn(scsn), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_bsb(reg_bsb),
        .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign outs = {miso, miso_oe, reg_addr, reg_bsb, reg_wdata, reg_wr, reg_rd,
                   frame_done, frame_err, busy};

    // register-file stand-in: returns the inverted low address byte one clock after reg_rd
    always @(posedge clk or posedge rst) begin
        if (rst)         reg_rdata <= 8'h00;
        else if (reg_rd) reg_rdata <= reg_addr[7:0] ^ 8'hFF;
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic got(input ev_t e);
        ev_t x;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=%h expected=none", e);
        end else begin
            x = exp_q.pop_front();
            chk("event", 40'(e), 40'(x));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_wr && reg_rd) chk("wr_rd_overlap", 40'({reg_wr, reg_rd}), 40'(2'b10));
            if (reg_wr)     got({K_WR, reg_addr, reg_wdata, reg_bsb});
            if (reg_rd)     got({K_RD, reg_addr, 8'h00, reg_bsb});
            if (frame_done) got({K_DONE, 16'h0000, 8'h00, 5'd0});
            if (frame_err)  got({K_ERR, 16'h0000, 8'h00, 5'd0});
        end
    end

    task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d,
                        input logic [4:0] b);
        exp_q.push_back({k, a, d, b});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            tick(HALF);
            sclk   = 1'b1;
            rx[i]  = miso;
            tick(HALF);
            sclk   = 1'b0;
        end
    endtask

    task automatic hdr(input logic [15:0] a, input logic [7:0] c);
        logic [7:0] d;
        scsn = 1'b0;
        tick(4);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        spi_bits(c, 8, d);
    endtask

    task automatic end_frame;
        tick(4);
        scsn = 1'b1;
        tick(20);
    endtask

    task automatic sb_empty(input string name);
        chk(name, 40'(exp_q.size()), 40'd0);
    endtask

    task automatic scen_write;
        logic [7:0] d;
        push(K_WR, 16'h0012, 8'hA5, 5'd0);
        push(K_WR, 16'h0013, 8'h3C, 5'd0);
        push(K_DONE, 16'h0000, 8'h00, 5'd0);
        hdr(16'h0012, 8'h04);
        spi_bits(8'hA5, 8, d);
        spi_bits(8'h3C, 8, d);
        chk("wr_busy", 40'(busy), 40'd1);
        chk("wr_oe", 40'(miso_oe), 40'd0);
        end_frame;
        sb_empty("wr_sb");
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rd_exp [3];
        rd_exp[0] = 8'hFF;
        rd_exp[1] = 8'hFE;
        rd_exp[2] = 8'hFD;
        rst  = 1'b1;
        scsn = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(3);
        chk("reset_outs", 40'(outs), 40'd0);
        rst = 1'b0;
        tick(5);
        chk("idle_busy", 40'(busy), 40'd0);

        scen_write;

        push(K_RD, 16'h0100, 8'h00, 5'd1);
        push(K_RD, 16'h0101, 8'h00, 5'd1);
        push(K_RD, 16'h0102, 8'h00, 5'd1);
        push(K_RD, 16'h0103, 8'h00, 5'd1);
        push(K_DONE, 16'h0000, 8'h00, 5'd0);
        hdr(16'h0100, 8'h08);
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, d);
            chk($sformatf("rd_miso_%0d", i), 40'(d), 40'(rd_exp[i]));
        end
        chk("rd_oe_on", 40'(miso_oe), 40'd1);
        end_frame;
        chk("rd_oe_off", 40'(miso_oe), 40'd0);
        sb_empty("rd_sb");

        push(K_WR, 16'hFFFF, 8'h11, 5'd0);
        push(K_WR, 16'h0000, 8'h22, 5'd0);
        push(K_DONE, 16'h0000, 8'h00, 5'd0);
        hdr(16'hFFFF, 8'h04);
        spi_bits(8'h11, 8, d);
        spi_bits(8'h22, 8, d);
        end_frame;
        sb_empty("wrap_sb");

        push(K_ERR, 16'h0000, 8'h00, 5'd0);
        hdr(16'h0020, 8'h04);
        spi_bits(8'hB0, 5, d);
        end_frame;
        chk("abort_oe", 40'(miso_oe), 40'd0);
        sb_empty("abort_sb");

        push(K_ERR, 16'h0000, 8'h00, 5'd0);
        hdr(16'h0030, 8'h05);
        tick(2);
        sb_empty("om_err_after_hdr");
        spi_bits(8'h5A, 8, d);
        end_frame;
        sb_empty("om_sb");
        chk("om_busy", 40'(busy), 40'd0);

        push(K_RD, 16'h0200, 8'h00, 5'd1);
        hdr(16'h0200, 8'h08);
        spi_bits(8'h00, 3, d);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        chk("midframe_rst_outs", 40'(outs), 40'd0);
        sb_empty("midframe_sb");
        scsn = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(10);
        sb_empty("post_rst_quiet");

        scen_write;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
